// File: rtl/hbridge_pwm_decoder_pkg.sv
// Shared H-bridge definitions: PWM period/duty scale and the legal gate patterns used by drive and decode paths.
package hbridge_pwm_decoder_pkg;

  localparam int FREQ_NEG_POW    = 10;
  localparam int DUTY_CYCLE_SIZE = 8;

  localparam logic [3:0] GATE_OFF = 4'b0000;
  localparam logic [3:0] GATE_FWD = 4'b1001;
  localparam logic [3:0] GATE_REV = 4'b0110;

  typedef enum logic [1:0] {
    GCLASS_OFF,
    GCLASS_ACTIVE,
    GCLASS_ILLEGAL
  } gate_class_e;

  function automatic gate_class_e classify_gate(input logic [3:0] g);
    if (g == GATE_OFF) return GCLASS_OFF;
    if ((g == GATE_FWD) || (g == GATE_REV)) return GCLASS_ACTIVE;
    return GCLASS_ILLEGAL;
  endfunction

endpackage

// File: rtl/hbridge_pwm_decoder_gate_sync_filter.sv
// Gate pattern synchronizer and classifier; PWM_DECODE_FILTER_EN adds a 3-sample stability filter
// so only patterns held for three consecutive samples reach the classifier.
module gate_sync_filter
  import hbridge_pwm_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] gate_in,
  output logic       active,
  output logic       dir,
  output logic       illegal
);

  logic [3:0]  sync1_q;
  logic [3:0]  sync2_q;
  logic [3:0]  samp;
  gate_class_e samp_class;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gate_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_DECODE_FILTER_EN
  logic [3:0] hist0_q;
  logic [3:0] hist1_q;
  logic [3:0] filt_q;

  // Dead-time and switching glitches never last three samples, so they never pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist0_q <= '0;
      hist1_q <= '0;
      filt_q  <= '0;
    end else begin
      hist0_q <= sync2_q;
      hist1_q <= hist0_q;
      if ((sync2_q == hist0_q) && (hist0_q == hist1_q)) begin
        filt_q <= sync2_q;
      end
    end
  end

  assign samp = filt_q;
`else
  assign samp = sync2_q;
`endif

  always_comb begin
    samp_class = classify_gate(samp);
    active     = (samp_class == GCLASS_ACTIVE);
    illegal    = (samp_class == GCLASS_ILLEGAL);
    dir        = (samp == GATE_FWD);
  end

endmodule

// File: rtl/hbridge_pwm_decoder.sv
// Recovers direction, on/off and duty from an H-bridge gate pattern over 2^PERIOD_POW-cycle windows.
// Optional PWM_DECODE_FILTER_EN inserts a stability filter ahead of classification.
module hbridge_pwm_decoder
  import hbridge_pwm_decoder_pkg::*;
#(
  parameter int PERIOD_POW = FREQ_NEG_POW,
  parameter int DUTY_BITS  = DUTY_CYCLE_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           gate_in,
  input  logic                 fault_clr,
  output logic                 meas_valid,
  output logic                 meas_dir,
  output logic                 meas_on,
  output logic [DUTY_BITS-1:0] meas_duty,
  output logic                 meas_dir_chg,
  output logic                 fault
);

  localparam int                  SHIFT   = PERIOD_POW - DUTY_BITS;
  localparam logic [PERIOD_POW-1:0] WIN_ONE = 1;

  logic s_active, s_dir, s_illegal;

  gate_sync_filter u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .gate_in (gate_in),
    .active  (s_active),
    .dir     (s_dir),
    .illegal (s_illegal)
  );

  logic [PERIOD_POW-1:0] win_cnt_q, win_cnt_d;
  logic [PERIOD_POW:0]   hi_cnt_q, hi_cnt_d, hi_sum;
  logic                  last_dir_q, last_dir_d;
  logic                  saw1_q, saw1_d, saw0_q, saw0_d;
  logic                  meas_valid_q, meas_valid_d;
  logic                  meas_on_q, meas_on_d;
  logic                  meas_dir_q, meas_dir_d;
  logic [DUTY_BITS-1:0]  meas_duty_q, meas_duty_d, duty_sat;
  logic                  meas_dir_chg_q, meas_dir_chg_d;
  logic                  fault_q, fault_d;
  logic                  win_end, saw1_now, saw0_now, last_dir_now;

  always_comb begin
    win_end      = &win_cnt_q;
    hi_sum       = hi_cnt_q + {{PERIOD_POW{1'b0}}, s_active};
    saw1_now     = saw1_q | (s_active & s_dir);
    saw0_now     = saw0_q | (s_active & ~s_dir);
    last_dir_now = s_active ? s_dir : last_dir_q;
    // A fully-on window reaches 2^PERIOD_POW, one past the duty range.
    duty_sat     = hi_sum[PERIOD_POW] ? {DUTY_BITS{1'b1}} : hi_sum[SHIFT +: DUTY_BITS];

    win_cnt_d      = win_cnt_q + WIN_ONE;
    hi_cnt_d       = hi_sum;
    saw1_d         = saw1_now;
    saw0_d         = saw0_now;
    last_dir_d     = last_dir_now;
    meas_valid_d   = win_end;
    meas_on_d      = meas_on_q;
    meas_dir_d     = meas_dir_q;
    meas_duty_d    = meas_duty_q;
    meas_dir_chg_d = meas_dir_chg_q;

    if (win_end) begin
      meas_on_d      = (hi_sum != '0);
      meas_dir_d     = (hi_sum != '0) ? last_dir_now : meas_dir_q;
      meas_duty_d    = duty_sat;
      meas_dir_chg_d = saw1_now & saw0_now;
      hi_cnt_d       = '0;
      saw1_d         = 1'b0;
      saw0_d         = 1'b0;
    end

    fault_d = s_illegal ? 1'b1 : (fault_clr ? 1'b0 : fault_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt_q      <= '0;
      hi_cnt_q       <= '0;
      last_dir_q     <= 1'b0;
      saw1_q         <= 1'b0;
      saw0_q         <= 1'b0;
      meas_valid_q   <= 1'b0;
      meas_on_q      <= 1'b0;
      meas_dir_q     <= 1'b0;
      meas_duty_q    <= '0;
      meas_dir_chg_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      win_cnt_q      <= win_cnt_d;
      hi_cnt_q       <= hi_cnt_d;
      last_dir_q     <= last_dir_d;
      saw1_q         <= saw1_d;
      saw0_q         <= saw0_d;
      meas_valid_q   <= meas_valid_d;
      meas_on_q      <= meas_on_d;
      meas_dir_q     <= meas_dir_d;
      meas_duty_q    <= meas_duty_d;
      meas_dir_chg_q <= meas_dir_chg_d;
      fault_q        <= fault_d;
    end
  end

  assign meas_valid   = meas_valid_q;
  assign meas_on      = meas_on_q;
  assign meas_dir     = meas_dir_q;
  assign meas_duty    = meas_duty_q;
  assign meas_dir_chg = meas_dir_chg_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_hbridge_pwm_decoder.sv
// Scoreboard bench for hbridge_pwm_decoder (64-cycle window, 4-bit duty); follows PWM_DECODE_FILTER_EN if defined.
module tb_hbridge_pwm_decoder;

  localparam int P   = 6;
  localparam int D   = 4;
  localparam int WIN = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] gate_in = 4'b0000;
  logic       fault_clr = 1'b0;
  logic       meas_valid, meas_dir, meas_on, meas_dir_chg, fault;
  logic [D-1:0] meas_duty;

  hbridge_pwm_decoder #(.PERIOD_POW(P), .DUTY_BITS(D)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .gate_in      (gate_in),
    .fault_clr    (fault_clr),
    .meas_valid   (meas_valid),
    .meas_dir     (meas_dir),
    .meas_on      (meas_on),
    .meas_duty    (meas_duty),
    .meas_dir_chg (meas_dir_chg),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         on;
    logic         dir;
    logic [D-1:0] duty;
    logic         chg;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] win_samples[$];
  logic       prev_dir;
  int         drv_cnt;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         release_cyc = -1;
  int         win_idx = 0;
  logic [3:0] raw_h0, raw_h1, filt_m;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: one window = 64 consecutive classified samples, summarised arithmetically.
  function automatic void close_window();
    int   hi = 0;
    logic s1 = 1'b0, s0 = 1'b0, ld = 1'b0;
    exp_t e;
    for (int i = 0; i < WIN; i++) begin
      logic [3:0] x;
      x = win_samples.pop_front();
      if (x == 4'b1001) begin hi++; s1 = 1'b1; ld = 1'b1; end
      else if (x == 4'b0110) begin hi++; s0 = 1'b1; ld = 1'b0; end
    end
    e.on   = (hi != 0);
    e.duty = (hi * (1 << D) / WIN > (1 << D) - 1) ? D'((1 << D) - 1) : D'(hi * (1 << D) / WIN);
    e.dir  = e.on ? ld : prev_dir;
    e.chg  = s1 & s0;
    prev_dir = e.dir;
    exp_q.push_back(e);
  endfunction

  function automatic void push_stage(logic [3:0] v);
    win_samples.push_back(v);
    if (win_samples.size() == WIN) close_window();
  endfunction

  // Raw stream = gate_in as seen after the synchronizer.
  function automatic void push_raw(logic [3:0] v);
`ifdef PWM_DECODE_FILTER_EN
    if ((v == raw_h0) && (raw_h0 == raw_h1)) filt_m = v;
    raw_h1 = raw_h0;
    raw_h0 = v;
    push_stage(filt_m);
`else
    push_stage(v);
`endif
  endfunction

  function automatic void model_reset();
    win_samples.delete();
    exp_q.delete();
    prev_dir = 1'b0;
    drv_cnt  = 0;
    raw_h0 = 4'b0; raw_h1 = 4'b0; filt_m = 4'b0;
`ifdef PWM_DECODE_FILTER_EN
    push_stage(4'b0000);
`endif
    push_raw(4'b0000);
    push_raw(4'b0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    gate_in = v;
    push_raw(v);
    drv_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    model_reset();
    release_cyc = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_meas_valid"}, 32'(meas_valid), 0);
    chk({tag, "_meas_on"}, 32'(meas_on), 0);
    chk({tag, "_meas_dir"}, 32'(meas_dir), 0);
    chk({tag, "_meas_duty"}, 32'(meas_duty), 0);
    chk({tag, "_meas_dir_chg"}, 32'(meas_dir_chg), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
  endtask

  // Monitor: every meas_valid pulse is matched against the oldest expected window.
  int mon_release_seen = -1;
  always @(negedge clk) begin
    if (reset_n && meas_valid) begin
      exp_t a, e;
      if (mon_release_seen != release_cyc) begin
        mon_release_seen = release_cyc;
        checks++;
        if (cyc - release_cyc != WIN) begin
          errors++;
          $display("FAIL first_pulse_latency actual=%0d required=%0d", cyc - release_cyc, WIN);
        end
      end
      a = '{on: meas_on, dir: meas_dir, duty: meas_duty, chg: meas_dir_chg};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL window_unexpected actual on=%0d dir=%0d duty=%0d chg=%0d required no pulse",
                 a.on, a.dir, a.duty, a.chg);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL window_%0d actual on=%0d dir=%0d duty=%0d chg=%0d required on=%0d dir=%0d duty=%0d chg=%0d",
                   win_idx, a.on, a.dir, a.duty, a.chg, e.on, e.dir, e.duty, e.chg);
        end else begin
          $display("window %0d on=%0d dir=%0d duty=%0d chg=%0d", win_idx, a.on, a.dir, a.duty, a.chg);
        end
      end
      win_idx++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    int n_on;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    release_reset();

    repeat (2 * WIN) drive(4'b0000);
    repeat (3 * WIN) drive(4'b1001);
    repeat (4) for (int i = 0; i < WIN; i++) drive(i < 24 ? 4'b0110 : 4'b0000);
    repeat (96) drive(4'b1001);
    repeat (128) drive(4'b0110);

    // Single-cycle illegal pattern, then clear.
    drive(4'b1111);
    drive(4'b0000);
    drive(4'b0000);
`ifdef PWM_DECODE_FILTER_EN
    chk("fault_single_glitch", 32'(fault), 0);
`else
    chk("fault_single_glitch", 32'(fault), 1);
`endif
    fault_clr = 1'b1;
    drive(4'b0000);
    fault_clr = 1'b0;
    chk("fault_cleared", 32'(fault), 0);

    // Clear asserted while illegal samples arrive: set must win.
    fault_clr = 1'b1;
    repeat (8) drive(4'b1111);
    chk("fault_set_beats_clr", 32'(fault), 1);
    fault_clr = 1'b0;
    repeat (8) drive(4'b0000);
    chk("fault_sticky", 32'(fault), 1);
    fault_clr = 1'b1;
    drive(4'b0000);
    fault_clr = 1'b0;
    chk("fault_cleared2", 32'(fault), 0);

    for (int w = 0; w < 6; w++) begin
      n_on = $urandom_range(0, WIN);
      v = ($urandom_range(0, 1) != 0) ? 4'b1001 : 4'b0110;
      for (int i = 0; i < WIN; i++) drive(i < n_on ? v : 4'b0000);
    end

    for (int i = 0; i < 2 * WIN; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 8) v = 4'b0000;
      else if (r < 13) v = 4'b1001;
      else if (r < 19) v = 4'b0110;
      else v = 4'($urandom_range(0, 15));
      drive(v);
    end

    // Reset at win_cnt == 40 discards the window in progress.
    while ((drv_cnt % WIN) != 40) drive(($urandom_range(0, 1) != 0) ? 4'b1001 : 4'b0000);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    release_reset();

    repeat (WIN + 10) drive(4'b1001);
    repeat (WIN) drive(($urandom_range(0, 3) == 0) ? 4'b0110 : 4'b0000);

    while (win_samples.size() != 0) drive(4'b0000);
    repeat (8) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
